pc_unit: RTL

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/cpu_pkg.sv | 6 +
 rtl/pc_unit_if.sv | 25 ++
 rtl/pc_unit_ret_stack.sv | 40 ++++
 rtl/pc_unit.sv | 73 +++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared PC-unit defaults and the RUN/HALT state encoding.
package cpu_pkg;
    localparam int PC_W_DEF  = 10;
    localparam int DEPTH_DEF = 8;
    typedef enum logic {RUN, HALT} state_t;
endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: instruction-sequencing bus between the decoder (master) and pc_unit (slave).
interface pc_unit_if #(
    parameter int PC_W  = cpu_pkg::PC_W_DEF,
    parameter int DEPTH = cpu_pkg::DEPTH_DEF
);
    logic                   s_inc;
    logic                   push;
    logic                   pop;
    logic [PC_W-1:0]        target;
    logic [PC_W-1:0]        pc;
    logic [$clog2(DEPTH):0] depth;
    logic                   full;
    logic                   empty;
    logic                   ovf;
    logic                   unf;
    logic                   halted;
    modport master (
        output s_inc, push, pop, target,
        input  pc, depth, full, empty, ovf, unf, halted
    );
    modport slave (
        input  s_inc, push, pop, target,
        output pc, depth, full, empty, ovf, unf, halted
    );
endinterface

// File: rtl/pc_unit_ret_stack.sv
// ret_stack: circular return-address stack with write port, read-top port and depth count.
module ret_stack #(
    parameter int W     = 10,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr,
    input  logic                   rd,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           top,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] ptr;
    logic [AW-1:0] below;
    assign below = ptr - 1'b1;
    assign top   = mem[below];
    assign full  = depth == (AW+1)'(DEPTH);
    assign empty = depth == '0;
    // The pointer wraps freely; depth saturates so a full push overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            depth <= '0;
        end else if (rd) begin
            ptr   <= below;
            depth <= empty ? depth : depth - 1'b1;
        end else if (wr) begin
            ptr   <= ptr + 1'b1;
            depth <= full ? depth : depth + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset && wr && !rd) mem[ptr] <= wdata;
    end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with call/return stack and RUN/HALT FSM.
// Define PC_STACK_GUARD_EN to halt on stack overflow/underflow instead of wrapping.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input logic      clk,
    input logic      reset,
    pc_unit_if.slave bus
);
`ifdef PC_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt, pc_inc, top;
    logic            ovf, unf, run, do_push, do_pop, ovf_ev, unf_ev, err, wr, rd, full, empty;
    assign pc_inc = pc + 1'b1;
    ret_stack #(.W(PC_W), .DEPTH(DEPTH)) u_stack (
        .clk   (clk),
        .reset (reset),
        .wr    (wr),
        .rd    (rd),
        .wdata (pc_inc),
        .top   (top),
        .depth (bus.depth),
        .full  (full),
        .empty (empty)
    );
    // Pop outranks push; a guarded stack error freezes everything and halts.
    always_comb begin
        run       = state == RUN;
        do_pop    = run && bus.pop;
        do_push   = run && bus.push && !bus.pop;
        ovf_ev    = do_push && full;
        unf_ev    = do_pop && empty;
        err       = GUARD && (ovf_ev || unf_ev);
        wr        = do_push && !err;
        rd        = do_pop && !err;
        state_nxt = err ? HALT : state;
        pc_nxt    = (!run || err) ? pc :
                    rd            ? top :
                    wr            ? bus.target :
                    bus.s_inc     ? pc_inc : bus.target;
    end
    always_ff @(posedge clk) begin
        state <= reset ? RUN : state_nxt;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            pc  <= pc_nxt;
            ovf <= ovf | ovf_ev;
            unf <= unf | unf_ev;
        end
    end
    assign bus.pc    = pc;
    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.ovf   = ovf;
    assign bus.unf   = unf;
`ifdef PC_STACK_GUARD_EN
    assign bus.halted = state == HALT;
`else
    assign bus.halted = 1'b0;
`endif
endmodule
